// File: rtl/mem_stage_if.sv
// Shared byte-wide RAM port seen by the MEM stage: arbiter request/grant plus
// address, write strobe and data in both directions.
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              mem_req;
  logic              mem_grant;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;

  modport master (
    output mem_req, mem_a, mem_wr, mem_dout,
    input  mem_grant, mem_din
  );

  modport slave (
    input  mem_req, mem_a, mem_wr, mem_dout,
    output mem_grant, mem_din
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial loads/stores over an arbitrated 8-bit RAM
// port, stalling EX/MEM while busy and registering write-back results.
module mem_stage #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdE_in,
  input  logic [4:0]        rdIdx_in,
  input  logic [31:0]       rdData_in,
  input  logic [3:0]        memOp_in,
  input  logic [31:0]       storeData_in,
  output logic              stall_out,
  mem_stage_if.master       mem,
  output logic              rdE_out,
  output logic [4:0]        rdIdx_out,
  output logic [31:0]       rdData_out
);

  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  size;
  logic [3:0]        op;
  logic [ADDR_W-1:0] base;
  logic [31:0]       sdata;
  logic [31:0]       lbuf;
  logic [31:0]       ld_word;
  logic [31:0]       ld_ext;
  logic              lat_rde;
  logic [4:0]        lat_idx;
  logic              op_in_valid;
  logic              is_store;
  logic              issue;
  logic              last;
  logic [1:0]        lane;

  assign op_in_valid = (memOp_in >= OP_LB) && (memOp_in <= OP_SW);
  assign is_store    = (op >= OP_SB);

  always_comb begin
    case (op)
      OP_LB, OP_LBU, OP_SB: size = CNT_W'(1);
      OP_LH, OP_LHU, OP_SH: size = CNT_W'(2);
      default:              size = CNT_W'(4);
    endcase
  end

  // Loads run one extra capture-only cycle because read data lags its address.
  assign issue = (state == XFER) && (cnt < size);
  assign last  = (state == XFER) &&
                 (is_store ? (cnt == size - CNT_W'(1)) : (cnt == size));

  // Byte returned this cycle belongs to the address issued last cycle.
  assign lane    = 2'(cnt - CNT_W'(1));
  assign ld_word = lbuf | (32'(mem.mem_din) << {lane, 3'b000});

  always_comb begin
    case (op)
      OP_LB:   ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      OP_LH:   ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      OP_LBU:  ld_ext = {24'd0, ld_word[7:0]};
      OP_LHU:  ld_ext = {16'd0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  assign stall_out = !rst_in &&
                     (((state == IDLE) && op_in_valid) || (state == REQ) || (state == XFER));

  // RAM port decode; address/data only driven on issue cycles.
  always_comb begin
    mem.mem_req  = (state == REQ) || (state == XFER);
    mem.mem_a    = '0;
    mem.mem_wr   = 1'b0;
    mem.mem_dout = 8'd0;
    if (issue) begin
      mem.mem_a = base + ADDR_W'(cnt);
      if (is_store) begin
        mem.mem_wr   = 1'b1;
        mem.mem_dout = 8'(sdata >> {cnt[1:0], 3'b000});
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_in_valid)   state_nxt = REQ;
      REQ:     if (mem.mem_grant) state_nxt = XFER;
      XFER:    if (last)          state_nxt = DONE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt        <= '0;
      op         <= 4'd0;
      base       <= '0;
      sdata      <= 32'd0;
      lbuf       <= 32'd0;
      lat_rde    <= 1'b0;
      lat_idx    <= 5'd0;
      rdE_out    <= 1'b0;
      rdIdx_out  <= 5'd0;
      rdData_out <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (op_in_valid) begin
            op         <= memOp_in;
            base       <= rdData_in[ADDR_W-1:0];
            sdata      <= storeData_in;
            lat_rde    <= rdE_in;
            lat_idx    <= rdIdx_in;
            lbuf       <= 32'd0;
            cnt        <= '0;
            rdE_out    <= 1'b0;
            rdIdx_out  <= 5'd0;
            rdData_out <= 32'd0;
          end else begin
            rdE_out    <= rdE_in;
            rdIdx_out  <= rdIdx_in;
            rdData_out <= rdData_in;
          end
        end
        REQ: begin
          if (mem.mem_grant) cnt <= '0;
        end
        XFER: begin
          cnt <= cnt + CNT_W'(1);
          if (!is_store && (cnt != '0)) lbuf <= ld_word;
          if (last) begin
            rdE_out    <= is_store ? 1'b0  : lat_rde;
            rdIdx_out  <= is_store ? 5'd0  : lat_idx;
            rdData_out <= is_store ? 32'd0 : ld_ext;
          end
        end
        default: begin
          rdE_out    <= 1'b0;
          rdIdx_out  <= 5'd0;
          rdData_out <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: per-cycle expectations built from a byte-array memory
// model and instruction-level timing, checked every cycle at the falling edge.
module tb_mem_stage;
  localparam int unsigned AW     = 17;
  localparam int unsigned RAM_SZ = 1 << AW;

  typedef struct packed {
    logic        stall;
    logic        req;
    logic        wr;
    logic [16:0] a;
    logic [7:0]  dout;
    logic        rde;
    logic [4:0]  idx;
    logic [31:0] data;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rde;
  logic [4:0]  ridx;
  logic [31:0] rdata;
  logic [3:0]  mop;
  logic [31:0] sdat;
  logic        stall;
  logic        oe;
  logic [4:0]  oidx;
  logic [31:0] odata;

  logic [7:0]  ram     [RAM_SZ];
  logic [7:0]  exp_ram [RAM_SZ];

  rec_t        exp_q[$];
  rec_t        cur_chk;
  logic        cur_e;
  logic [4:0]  cur_idx;
  logic [31:0] cur_d;
  logic        snap_e;
  logic [4:0]  snap_idx;
  logic [31:0] snap_d;
  int          stall_cnt;
  int          n_checks;
  int          n_fail;

  mem_stage_if #(.ADDR_W(AW)) bus ();

  mem_stage #(.ADDR_W(AW)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .rdE_in       (rde),
    .rdIdx_in     (ridx),
    .rdData_in    (rdata),
    .memOp_in     (mop),
    .storeData_in (sdat),
    .stall_out    (stall),
    .mem          (bus.master),
    .rdE_out      (oe),
    .rdIdx_out    (oidx),
    .rdData_out   (odata)
  );

  always #5 clk = ~clk;

  // Byte RAM: synchronous write, read data appears the cycle after the address.
  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a];
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endfunction

  function automatic rec_t mk(input logic s, input logic q, input logic w,
                              input logic [16:0] a, input logic [7:0] d,
                              input logic e, input logic [4:0] i, input logic [31:0] x);
    rec_t r;
    r.stall = s; r.req = q; r.wr = w; r.a = a; r.dout = d;
    r.rde = e; r.idx = i; r.data = x;
    return r;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur_chk = exp_q.pop_front();
      chk("stall",  32'(stall),        32'(cur_chk.stall));
      chk("req",    32'(bus.mem_req),  32'(cur_chk.req));
      chk("wr",     32'(bus.mem_wr),   32'(cur_chk.wr));
      chk("addr",   32'(bus.mem_a),    32'(cur_chk.a));
      chk("dout",   32'(bus.mem_dout), 32'(cur_chk.dout));
      chk("rdE",    32'(oe),           32'(cur_chk.rde));
      chk("rdIdx",  32'(oidx),         32'(cur_chk.idx));
      chk("rdData", odata,             cur_chk.data);
    end
  end

  task automatic step(input rec_t r);
    exp_q.push_back(r);
    @(negedge clk);
    snap_e   = oe;
    snap_idx = oidx;
    snap_d   = odata;
    if (stall) stall_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rde = 1'b0; ridx = 5'd0; rdata = 32'd0; mop = 4'd0; sdat = 32'd0;
    bus.mem_grant = 1'b0;
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] b);
    ram[a]     = b;
    exp_ram[a] = b;
  endtask

  // Non-memory instruction: appears on the outputs one cycle later.
  task automatic alu_op(input logic e, input logic [4:0] i, input logic [31:0] d, input logic [3:0] op);
    rde = e; ridx = i; rdata = d; mop = op; sdat = 32'd0;
    step(mk(1'b0, 1'b0, 1'b0, 17'd0, 8'd0, cur_e, cur_idx, cur_d));
    cur_e = e; cur_idx = i; cur_d = d;
  endtask

  task automatic mem_op(input logic [3:0] op, input logic e, input logic [4:0] i,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input int gdelay, input int rst_at);
    logic [AW-1:0] base;
    logic [AW-1:0] a;
    logic [31:0]   w;
    logic [7:0]    b;
    int            n;
    bit            st;
    base = addr[AW-1:0];
    n  = (op == 4'd1 || op == 4'd4 || op == 4'd6) ? 1 :
         (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 : 4;
    st = (op >= 4'd6);
    w  = 32'd0;
    for (int j = 0; j < n; j++) begin
      a = base + AW'(j);
      w = w | (32'(exp_ram[a]) << (8 * j));
    end
    case (op)
      4'd1:    w = {{24{w[7]}}, w[7:0]};
      4'd2:    w = {{16{w[15]}}, w[15:0]};
      default: w = w;
    endcase

    rde = e; ridx = i; rdata = addr; mop = op; sdat = sd; bus.mem_grant = 1'b0;
    step(mk(1'b1, 1'b0, 1'b0, 17'd0, 8'd0, cur_e, cur_idx, cur_d));
    cur_e = 1'b0; cur_idx = 5'd0; cur_d = 32'd0;

    for (int g = 0; g <= gdelay; g++) begin
      bus.mem_grant = (g == gdelay);
      step(mk(1'b1, 1'b1, 1'b0, 17'd0, 8'd0, 1'b0, 5'd0, 32'd0));
    end

    for (int k = 0; k < (st ? n : n + 1); k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        step(mk(1'b0, 1'b0, 1'b0, 17'd0, 8'd0, 1'b0, 5'd0, 32'd0));
        rst = 1'b0;
        set_idle();
        return;
      end
      bus.mem_grant = 1'b1;
      if (k < n) begin
        a = base + AW'(k);
        b = st ? sd[8*k +: 8] : 8'd0;
        if (st) exp_ram[a] = b;
        step(mk(1'b1, 1'b1, st, a, b, 1'b0, 5'd0, 32'd0));
      end else begin
        step(mk(1'b1, 1'b1, 1'b0, 17'd0, 8'd0, 1'b0, 5'd0, 32'd0));
      end
    end

    bus.mem_grant = 1'b0;
    if (st) step(mk(1'b0, 1'b0, 1'b0, 17'd0, 8'd0, 1'b0, 5'd0, 32'd0));
    else    step(mk(1'b0, 1'b0, 1'b0, 17'd0, 8'd0, e, i, w));
    set_idle();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; stall_cnt = 0;
    cur_e = 1'b0; cur_idx = 5'd0; cur_d = 32'd0;
    for (int j = 0; j < int'(RAM_SZ); j++) begin
      ram[j]     = 8'd0;
      exp_ram[j] = 8'd0;
    end
    poke(17'h00100, 8'h80);
    poke(17'h1FFFF, 8'h34);
    poke(17'h00000, 8'h12);
    poke(17'h00300, 8'h44);
    poke(17'h00301, 8'h33);
    poke(17'h00302, 8'h22);
    poke(17'h00303, 8'h11);

    rst = 1'b1;
    set_idle();
    step(mk(1'b0, 1'b0, 1'b0, 17'd0, 8'd0, 1'b0, 5'd0, 32'd0));
    chk("reset_data", snap_d, 32'd0);
    rst = 1'b0;
    step(mk(1'b0, 1'b0, 1'b0, 17'd0, 8'd0, 1'b0, 5'd0, 32'd0));

    // Pass-through, including an unused op code.
    alu_op(1'b1, 5'd5, 32'h0000_1234, 4'd0);
    alu_op(1'b1, 5'd7, 32'hCAFE_BABE, 4'd12);
    chk("pass_data", snap_d, 32'h0000_1234);
    chk("pass_idx", 32'(snap_idx), 32'd5);
    alu_op(1'b0, 5'd0, 32'd0, 4'd0);
    chk("op12_data", snap_d, 32'hCAFE_BABE);

    stall_cnt = 0;
    mem_op(4'd1, 1'b1, 5'd3, 32'h0000_0100, 32'd0, 0, -1);
    chk("lb_data", snap_d, 32'hFFFF_FF80);
    chk("lb_rde", 32'(snap_e), 32'd1);
    chk("lb_stall_cycles", 32'(stall_cnt), 32'd4);
    mem_op(4'd4, 1'b1, 5'd4, 32'h0000_0100, 32'd0, 0, -1);
    chk("lbu_data", snap_d, 32'h0000_0080);

    mem_op(4'd8, 1'b1, 5'd9, 32'h0000_0200, 32'hDEAD_BEEF, 0, -1);
    chk("sw_rde", 32'(snap_e), 32'd0);
    chk("sw_b0", 32'(ram[17'h200]), 32'hEF);
    chk("sw_b1", 32'(ram[17'h201]), 32'hBE);
    chk("sw_b2", 32'(ram[17'h202]), 32'hAD);
    chk("sw_b3", 32'(ram[17'h203]), 32'hDE);
    mem_op(4'd3, 1'b1, 5'd10, 32'h0000_0200, 32'd0, 0, -1);
    chk("lw_back", snap_d, 32'hDEAD_BEEF);

    mem_op(4'd2, 1'b1, 5'd11, 32'hABC1_FFFF, 32'd0, 0, -1);
    chk("lh_wrap", snap_d, 32'h0000_1234);

    mem_op(4'd7, 1'b1, 5'd14, 32'h0000_0401, 32'h1234_F00D, 1, -1);
    mem_op(4'd5, 1'b1, 5'd15, 32'h0000_0401, 32'd0, 0, -1);
    chk("lhu_data", snap_d, 32'h0000_F00D);
    mem_op(4'd2, 1'b0, 5'd16, 32'h0000_0401, 32'd0, 2, -1);
    chk("lh_neg", snap_d, 32'hFFFF_F00D);

    stall_cnt = 0;
    mem_op(4'd6, 1'b1, 5'd2, 32'h0000_0500, 32'h0000_005A, 3, -1);
    chk("sb_wait_stall_cycles", 32'(stall_cnt), 32'd6);
    chk("sb_byte", 32'(ram[17'h500]), 32'h5A);

    mem_op(4'd3, 1'b1, 5'd17, 32'h0001_FFFE, 32'd0, 2, -1);
    chk("lw_wrap", snap_d, 32'h0012_3400);

    // Reset lands on the third store byte; the write of that byte is cancelled.
    mem_op(4'd8, 1'b1, 5'd12, 32'h0000_0600, 32'h0102_0304, 0, 2);
    chk("rst_b1", 32'(ram[17'h601]), 32'h03);
    chk("rst_b2", 32'(ram[17'h602]), 32'h00);
    cur_e = 1'b0; cur_idx = 5'd0; cur_d = 32'd0;
    alu_op(1'b0, 5'd0, 32'd0, 4'd0);
    mem_op(4'd3, 1'b1, 5'd13, 32'h0000_0300, 32'd0, 0, -1);
    chk("lw_after_rst", snap_d, 32'h1122_3344);

    alu_op(1'b0, 5'd0, 32'd0, 4'd0);
    alu_op(1'b0, 5'd0, 32'd0, 4'd0);
    if (exp_q.size() != 0) chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
